instr_realign_stage: RTL

INSTR_REALIGN_STAGE -- requirements
Module: instr_realign_stage

---
 rtl/instr_realign_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instr_realign_stage.sv
// Realigns 32-bit fetch words into 16/32-bit RISC-V instructions through a registered output slot.
// Macro RVC_REALIGN_EN enables compressed-instruction realignment; undefined = pass-through.
module instr_realign_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [XLEN-1:0] fetch_addr_i,
  input  logic [31:0]     fetch_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_addr_o,
  output logic            instr_is_compressed_o
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            is_c_q, is_c_d;

  logic            slot_free;
  logic            accept;
  logic            emit;
  logic [31:0]     emit_instr;
  logic [XLEN-1:0] emit_addr;
  logic            emit_c;

  assign slot_free = !valid_q || instr_ready_i;
  assign accept    = fetch_valid_i && fetch_ready_o;

`ifdef RVC_REALIGN_EN
  typedef enum logic [1:0] {StIdle, StHalf, StPendC} state_e;

  state_e          state_q, state_d;
  logic [15:0]     held_q, held_d;
  logic [XLEN-1:0] held_addr_q, held_addr_d;

  logic [15:0]     lo_half, hi_half;
  logic [XLEN-1:0] upper_addr;

  function automatic logic is_compressed(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  assign lo_half    = fetch_data_i[15:0];
  assign hi_half    = fetch_data_i[31:16];
  assign upper_addr = {fetch_addr_i[XLEN-1:2], 2'b00} + XLEN'(2);

  assign fetch_ready_o = slot_free && (state_q != StPendC) && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      held_q      <= '0;
      held_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      held_addr_q <= held_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    held_addr_d = held_addr_q;
    emit        = 1'b0;
    emit_instr  = '0;
    emit_addr   = '0;
    emit_c      = 1'b0;
    if (flush_i) begin
      state_d = StIdle;
    end else if (state_q == StPendC) begin
      if (slot_free) begin
        emit       = 1'b1;
        emit_instr = {16'h0000, held_q};
        emit_addr  = held_addr_q;
        emit_c     = 1'b1;
        state_d    = StIdle;
      end
    end else if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (!fetch_addr_i[1]) begin
            emit      = 1'b1;
            emit_addr = fetch_addr_i;
            if (is_compressed(lo_half)) begin
              emit_instr  = {16'h0000, lo_half};
              emit_c      = 1'b1;
              held_d      = hi_half;
              held_addr_d = upper_addr;
              state_d     = is_compressed(hi_half) ? StPendC : StHalf;
            end else begin
              emit_instr = fetch_data_i;
            end
          end else if (is_compressed(hi_half)) begin
            emit       = 1'b1;
            emit_instr = {16'h0000, hi_half};
            emit_addr  = fetch_addr_i;
            emit_c     = 1'b1;
          end else begin
            held_d      = hi_half;
            held_addr_d = fetch_addr_i;
            state_d     = StHalf;
          end
        end
        StHalf: begin
          emit        = 1'b1;
          emit_instr  = {lo_half, held_q};
          emit_addr   = held_addr_q;
          held_d      = hi_half;
          held_addr_d = upper_addr;
          state_d     = is_compressed(hi_half) ? StPendC : StHalf;
        end
        default: ;
      endcase
    end
  end
`else
  assign fetch_ready_o = slot_free && !flush_i;

  always_comb begin
    emit       = accept && !flush_i;
    emit_instr = fetch_data_i;
    emit_addr  = fetch_addr_i;
    emit_c     = 1'b0;
  end
`endif

  // A consumed slot empties unless refilled the same cycle; flush always empties it.
  always_comb begin
    valid_d = valid_q && !instr_ready_i;
    instr_d = instr_q;
    addr_d  = addr_q;
    is_c_d  = is_c_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (emit) begin
      valid_d = 1'b1;
      instr_d = emit_instr;
      addr_d  = emit_addr;
      is_c_d  = emit_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      is_c_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      is_c_q  <= is_c_d;
    end
  end

  assign instr_valid_o         = valid_q;
  assign instr_o               = instr_q;
  assign instr_addr_o          = addr_q;
  assign instr_is_compressed_o = is_c_q;

endmodule
